// File: rtl/dl_1_16_demux_capture_pkg.sv
// Shared constants and state encoding for the 1:16 demux capture block.
// Optional parity phase is enabled by defining DL_DEMUX_PARITY_EN.
package dl_1_16_demux_capture_pkg;

    localparam int WIDTH = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PARITY  = 1'b1
    } state_t;

    // Non-zero when data plus its even-parity bit do not XOR to zero.
    function automatic logic parity_error(input logic [WIDTH-1:0] data, input logic parity_bit);
        return (^data) ^ parity_bit;
    endfunction

endpackage

// File: rtl/dl_1_16_demux_capture_if.sv
// Serial-in / word-out bundle for the demux capture block.
// parity_err exists only when DL_DEMUX_PARITY_EN is defined.
interface dl_1_16_demux_capture_if;
    import dl_1_16_demux_capture_pkg::*;

    logic             d;
    logic             d_valid;
    logic             d_ready;
    logic             sync;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ready;
    logic [SEL_W-1:0] sel;
    logic             overrun;
`ifdef DL_DEMUX_PARITY_EN
    logic             parity_err;
`endif

    // master: serializer/downstream side; slave: the capture block itself
    modport master (
        output d, d_valid, sync, word_ready,
`ifdef DL_DEMUX_PARITY_EN
        input  parity_err,
`endif
        input  d_ready, word, word_valid, sel, overrun
    );

    modport slave (
        input  d, d_valid, sync, word_ready,
`ifdef DL_DEMUX_PARITY_EN
        output parity_err,
`endif
        output d_ready, word, word_valid, sel, overrun
    );

endinterface

// File: rtl/dl_1_16_demux_capture_dec4to16.sv
// 4-bit select to 16-bit one-hot write enable, gated by a global enable.
// Counterpart of the 4:1 mux leaf used on the serializer side.
module dl_dec4to16
    import dl_1_16_demux_capture_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [WIDTH-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
            assign onehot[gi] = en && (sel == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/dl_1_16_demux_capture.sv
// Receiving end of a 16:1 mux serializer: steers serial bits into a 16-bit word.
// Define DL_DEMUX_PARITY_EN to expect an even-parity bit after every 16 data bits.
module dl_1_16_demux_capture
    import dl_1_16_demux_capture_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    dl_1_16_demux_capture_if.slave   bus
);

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [WIDTH-1:0] collect_reg, collect_next;
    logic [WIDTH-1:0] word_reg, word_next;
    logic             word_valid_reg, word_valid_next;
    logic             overrun_reg, overrun_next;
`ifdef DL_DEMUX_PARITY_EN
    logic             parity_err_reg, parity_err_next;
`endif

    logic             d_ready;
    logic             accept;
    logic             dec_en;
    logic [WIDTH-1:0] bit_en;
    logic [WIDTH-1:0] collect_wr;
    logic             commit;
    logic [WIDTH-1:0] commit_word;
    logic             commit_perr;

    assign d_ready = 1'b1;
    assign accept  = bus.d_valid && d_ready;
    assign dec_en  = accept && !bus.sync && (state_reg == ST_COLLECT);

    dl_dec4to16 u_dec (
        .sel    (sel_reg),
        .en     (dec_en),
        .onehot (bit_en)
    );

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_collect
            assign collect_wr[gi] = bit_en[gi] ? bus.d : collect_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_COLLECT;
            sel_reg        <= '0;
            collect_reg    <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef DL_DEMUX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            collect_reg    <= collect_next;
            word_reg       <= word_next;
            word_valid_reg <= word_valid_next;
            overrun_reg    <= overrun_next;
`ifdef DL_DEMUX_PARITY_EN
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        collect_next    = collect_reg;
        word_next       = word_reg;
        word_valid_next = word_valid_reg;
        overrun_next    = overrun_reg;
        commit          = 1'b0;
        commit_word     = collect_wr;
        commit_perr     = 1'b0;
`ifdef DL_DEMUX_PARITY_EN
        parity_err_next = parity_err_reg;
`endif

        // sync wins over a same-cycle bit, which is simply dropped
        if (bus.sync) begin
            sel_next     = '0;
            collect_next = '0;
            state_next   = ST_COLLECT;
        end else if (accept) begin
            case (state_reg)
                ST_COLLECT: begin
                    collect_next = collect_wr;
                    sel_next     = sel_reg + 1'b1;
                    if (sel_reg == SEL_W'(WIDTH - 1)) begin
`ifdef DL_DEMUX_PARITY_EN
                        state_next   = ST_PARITY;
`else
                        commit       = 1'b1;
                        commit_word  = collect_wr;
                        collect_next = '0;
`endif
                    end
                end
`ifdef DL_DEMUX_PARITY_EN
                ST_PARITY: begin
                    commit       = 1'b1;
                    commit_word  = collect_reg;
                    commit_perr  = parity_error(collect_reg, bus.d);
                    collect_next = '0;
                    state_next   = ST_COLLECT;
                end
`endif
                default: ;
            endcase
        end

        if (word_valid_reg && bus.word_ready) begin
            word_valid_next = 1'b0;
        end

        // A word still waiting for the consumer is never overwritten
        if (commit) begin
            if (!word_valid_reg || bus.word_ready) begin
                word_next       = commit_word;
                word_valid_next = 1'b1;
`ifdef DL_DEMUX_PARITY_EN
                parity_err_next = commit_perr;
`endif
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    assign bus.d_ready    = d_ready;
    assign bus.word       = word_reg;
    assign bus.word_valid = word_valid_reg;
    assign bus.sel        = sel_reg;
    assign bus.overrun    = overrun_reg;
`ifdef DL_DEMUX_PARITY_EN
    assign bus.parity_err = parity_err_reg;
`else
    logic unused_perr;
    assign unused_perr = commit_perr;
`endif

endmodule

// File: tb/tb_dl_1_16_demux_capture.sv
// Scoreboard bench for dl_1_16_demux_capture: directed streams plus random traffic.
// Builds with or without DL_DEMUX_PARITY_EN.
module tb_dl_1_16_demux_capture;
    import dl_1_16_demux_capture_pkg::*;

    logic clock = 1'b0;
    logic reset;

    dl_1_16_demux_capture_if bus();

    dl_1_16_demux_capture dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] w;
        logic        p;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: bit count, accumulated word, output slot occupancy
    int          m_cnt;
    logic [15:0] m_acc;
    logic        m_slot;
    logic        m_ov;
    logic        m_par;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_acc  = '0;
        m_slot = 1'b0;
        m_ov   = 1'b0;
        m_par  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic dd, input logic dv, input logic sy, input logic wr);
        logic        hs;
        logic        do_c;
        logic        loaded;
        logic [15:0] cw;
        logic        cp;
        hs     = m_slot && wr;
        do_c   = 1'b0;
        loaded = 1'b0;
        cw     = '0;
        cp     = 1'b0;
        if (sy) begin
            m_cnt = 0;
            m_acc = '0;
            m_par = 1'b0;
        end else if (dv) begin
            if (m_par) begin
                do_c  = 1'b1;
                cw    = m_acc;
                cp    = (^m_acc) ^ dd;
                m_acc = '0;
                m_par = 1'b0;
            end else begin
                m_acc[m_cnt] = dd;
                m_cnt = (m_cnt + 1) % 16;
                if (m_cnt == 0) begin
`ifdef DL_DEMUX_PARITY_EN
                    m_par = 1'b1;
`else
                    do_c  = 1'b1;
                    cw    = m_acc;
                    m_acc = '0;
`endif
                end
            end
        end
        if (do_c) begin
            if (m_slot && !wr) begin
                m_ov = 1'b1;
            end else begin
                exp_q.push_back('{cw, cp});
                loaded = 1'b1;
            end
        end
        m_slot = loaded ? 1'b1 : (hs ? 1'b0 : m_slot);
    endtask

    task automatic step(input logic dd, input logic dv, input logic sy, input logic wr);
        bus.d          = dd;
        bus.d_valid    = dv;
        bus.sync       = sy;
        bus.word_ready = wr;
        @(posedge clock);
        model_edge(dd, dv, sy, wr);
        #1;
        chk("sel", 32'(bus.sel), 32'(m_cnt));
        chk("word_valid", 32'(bus.word_valid), 32'(m_slot));
        chk("overrun", 32'(bus.overrun), 32'(m_ov));
        chk("d_ready", 32'(bus.d_ready), 32'd1);
    endtask

    task automatic send_word(input logic [15:0] w, input int gap, input logic wr, input logic p);
        for (int i = 0; i < 16; i++) begin
            step(w[i], 1'b1, 1'b0, wr);
            for (int g = 0; g < gap; g++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, wr);
        end
`ifdef DL_DEMUX_PARITY_EN
        step(p, 1'b1, 1'b0, wr);
`else
        if (p === 1'bx) $display("parity bit unknown");
`endif
    endtask

    // Called right after a step (posedge+1): reset lands mid-cycle, away from any edge
    task automatic async_reset_check();
        #2;
        reset = 1'b1;
        #1;
        chk("async_sel", 32'(bus.sel), 32'd0);
        chk("async_word_valid", 32'(bus.word_valid), 32'd0);
        chk("async_overrun", 32'(bus.overrun), 32'd0);
        chk("async_word", 32'(bus.word), 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: handshake sampled at negedge completes on the following posedge
    always @(negedge clock) begin
        if (reset === 1'b0 && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none at %0t", bus.word, $time);
            end else begin
                e = exp_q.pop_front();
                chk("word", 32'(bus.word), 32'(e.w));
`ifdef DL_DEMUX_PARITY_EN
                chk("parity_err", 32'(bus.parity_err), 32'(e.p));
`endif
                $display("word %h accepted at %0t", bus.word, $time);
            end
        end
    end

    initial begin
        logic [15:0] w;
        bus.d          = 1'b0;
        bus.d_valid    = 1'b0;
        bus.sync       = 1'b0;
        bus.word_ready = 1'b0;
        reset          = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_word", 32'(bus.word), 32'd0);
        chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_d_ready", 32'(bus.d_ready), 32'd1);

        // Plain word, consumer always ready
        send_word(16'hA5C3, 0, 1'b1, ^16'hA5C3);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Consumer stalled: second word is lost and flagged
        send_word(16'hA5C3, 0, 1'b0, ^16'hA5C3);
        send_word(16'h1234, 0, 1'b0, ^16'h1234);
        chk("held_word", 32'(bus.word), 32'h0000A5C3);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Partial prefix then sync with a valid bit that must be discarded
        for (int i = 0; i < 7; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        send_word(16'hFFFF, 0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset with sel at 9
        for (int i = 0; i < 9; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
        async_reset_check();
        send_word(16'h0F0F, 0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Gapped valid, one in three cycles
        send_word(16'h8001, 2, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef DL_DEMUX_PARITY_EN
        send_word(16'h0003, 0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(16'h0007, 0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Randomized traffic including sync and backpressure
        for (int n = 0; n < 6; n++) begin
            w = 16'($urandom);
            send_word(w, 0, 1'b1, ^w);
        end
        for (int c = 0; c < 500; c++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 60) == 0), ($urandom_range(0, 2) != 0));
        end

        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
